// File: rtl/enemy_car_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : road_fighter_pkg
//  Purpose : Shared types and screen constants for the enemy-car datapath:
//            FSM state enum, coordinate types, fixed-point shift and bounds.
//  Revision: 1.0 - initial release
// ============================================================================
package road_fighter_pkg;

    typedef logic signed [10:0] coord_t;   // pixel coordinate
    typedef logic signed [16:0] yfp_t;     // Y in 1/64 px (Y << FP_SHIFT)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        CRASH  = 2'd2
    } state_t;

    localparam int     FP_SHIFT     = 6;
    localparam coord_t Y_START      = -11'sd64;
    localparam coord_t Y_BOTTOM     = 11'sd480;
    localparam coord_t X_MIN        = 11'sd160;
    localparam coord_t X_MAX        = 11'sd480;
    localparam int     CRASH_FRAMES = 30;
    localparam int     CNT_W        = $clog2(CRASH_FRAMES + 1);

    // Promote a pixel coordinate to fixed point (sign-extended).
    function automatic yfp_t to_fp(input coord_t px);
        return yfp_t'(px) <<< FP_SHIFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_car_mover_if.sv
`default_nettype none
// ============================================================================
//  Module  : enemy_car_mover_if
//  Purpose : Bundle between the frame/spawn source and the enemy-car mover.
//  Ports   : master drives startOfFrame, spawn_req, spawn_x, speed, collision
//            and observes topLeftX, topLeftY, active, crashed, done;
//            slave (the mover) is the mirror image.
//  Revision: 1.0 - initial release
// ============================================================================
interface enemy_car_mover_if;
    import road_fighter_pkg::*;

    logic        startOfFrame;
    logic        spawn_req;
    coord_t      spawn_x;
    logic [7:0]  speed;
    logic        collision;
    coord_t      topLeftX;
    coord_t      topLeftY;
    logic        active;
    logic        crashed;
    logic        done;

    modport master (
        output startOfFrame, spawn_req, spawn_x, speed, collision,
        input  topLeftX, topLeftY, active, crashed, done
    );

    modport slave (
        input  startOfFrame, spawn_req, spawn_x, speed, collision,
        output topLeftX, topLeftY, active, crashed, done
    );

endinterface
`default_nettype wire

// File: rtl/enemy_car_mover_frame_down_counter.sv
`default_nettype none
// ============================================================================
//  Module  : frame_down_counter
//  Purpose : Loadable frame counter that decrements on frame pulses and
//            flags when it is at zero or is reaching zero on this decrement.
//  Ports   : clk, rst (sync, active-high), i_load/i_load_value, i_dec,
//            o_zero
//  Revision: 1.0 - initial release
// ============================================================================
module frame_down_counter #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_value,
    input  wire logic             i_dec,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Look-ahead: lets the owner retire on the very frame that empties it.
    assign o_zero = (r_count == '0) ||
                    (i_dec && !i_load && (r_count == WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/enemy_car_mover.sv
`default_nettype none
// ============================================================================
//  Module  : enemy_car_mover
//  Purpose : Spawns one enemy car above the road, scrolls it down once per
//            frame in fixed-point Y, freezes it for a crash period on
//            collision, then retires it with a one-cycle done pulse.
//  Ports   : clk, reset (sync, active-high), bus (enemy_car_mover_if.slave)
//  Options : ENEMY_LATERAL_DRIFT_EN - car bounces in X between X_MIN/X_MAX
//            while moving; undefined keeps X at the latched spawn column.
//  Revision: 1.0 - initial release
// ============================================================================
module enemy_car_mover (
    input  wire logic          clk,
    input  wire logic          reset,
    enemy_car_mover_if.slave   bus
);
    import road_fighter_pkg::*;

    localparam yfp_t Y_START_FP  = to_fp(Y_START);
    localparam yfp_t Y_BOTTOM_FP = to_fp(Y_BOTTOM);

    state_t r_state;
    yfp_t   r_y_fp;
    coord_t r_x;
    coord_t r_top_y;
    logic   r_active;
    logic   r_crashed;
    logic   r_done;

    yfp_t   w_y_next;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_zero;

    // speed is unsigned; zero-extend before the signed add.
    assign w_y_next   = r_y_fp + yfp_t'({1'b0, bus.speed});
    assign w_cnt_load = (r_state == MOVING) && bus.collision;
    assign w_cnt_dec  = (r_state == CRASH) && bus.startOfFrame;

    frame_down_counter #(
        .WIDTH (CNT_W)
    ) u_crash_cnt (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_cnt_load),
        .i_load_value (CNT_W'(CRASH_FRAMES)),
        .i_dec        (w_cnt_dec),
        .o_zero       (w_cnt_zero)
    );

`ifdef ENEMY_LATERAL_DRIFT_EN
    logic   r_dir_neg;     // 0: moving right (+1), 1: moving left (-1)
    coord_t w_x_step;
    coord_t w_x_drift;
    logic   w_dir_next;

    // A step that would leave the band flips direction and steps inward.
    always_comb begin
        w_x_step   = r_dir_neg ? (r_x - 11'sd1) : (r_x + 11'sd1);
        w_x_drift  = w_x_step;
        w_dir_next = r_dir_neg;
        if ((w_x_step > X_MAX) || (w_x_step < X_MIN)) begin
            w_dir_next = !r_dir_neg;
            w_x_drift  = r_dir_neg ? (r_x + 11'sd1) : (r_x - 11'sd1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_y_fp    <= '0;
            r_x       <= '0;
            r_top_y   <= '0;
            r_active  <= 1'b0;
            r_crashed <= 1'b0;
            r_done    <= 1'b0;
`ifdef ENEMY_LATERAL_DRIFT_EN
            r_dir_neg <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_active  <= 1'b0;
                    r_crashed <= 1'b0;
                    if (bus.spawn_req) begin
                        r_x      <= bus.spawn_x;
                        r_y_fp   <= Y_START_FP;
                        r_top_y  <= Y_START;
                        r_active <= 1'b1;
                        r_state  <= MOVING;
`ifdef ENEMY_LATERAL_DRIFT_EN
                        r_dir_neg <= 1'b0;
`endif
                    end
                end
                MOVING: begin
                    // Collision has priority over the frame step.
                    if (bus.collision) begin
                        r_state   <= CRASH;
                        r_crashed <= 1'b1;
                    end else if (bus.startOfFrame) begin
                        r_y_fp  <= w_y_next;
                        r_top_y <= w_y_next[FP_SHIFT +: 11];
`ifdef ENEMY_LATERAL_DRIFT_EN
                        r_x       <= w_x_drift;
                        r_dir_neg <= w_dir_next;
`endif
                        if (w_y_next >= Y_BOTTOM_FP) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                CRASH: begin
                    if (w_cnt_dec && w_cnt_zero) begin
                        r_state   <= IDLE;
                        r_active  <= 1'b0;
                        r_crashed <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.topLeftX = r_x;
    assign bus.topLeftY = r_top_y;
    assign bus.active   = r_active;
    assign bus.crashed  = r_crashed;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_enemy_car_mover.sv
`default_nettype none
// ============================================================================
//  Module  : tb_enemy_car_mover
//  Purpose : Self-checking bench for enemy_car_mover: directed scenarios with
//            fixed expectations plus a randomized run against a pixel-level
//            behavioural model of the car.
//  Options : ENEMY_LATERAL_DRIFT_EN selects the drift scenario and model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_enemy_car_mover;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    enemy_car_mover_if bus ();

    enemy_car_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model (pixels, frames, integer Y*64) -----
    int m_mode;      // 0 idle, 1 moving, 2 crashed
    int m_yfp;
    int m_x;
    int m_tly;
    int m_frames_left;
    int m_dir;
    bit m_active, m_crashed, m_done;

    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_yfp = 0; m_x = 0; m_tly = 0; m_frames_left = 0;
            m_dir = 1; m_active = 0; m_crashed = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_mode == 0) begin
            m_active = 0; m_crashed = 0;
            if (bus.spawn_req) begin
                m_x = int'(bus.spawn_x); m_yfp = -64 * 64; m_tly = -64;
                m_dir = 1; m_active = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (bus.collision) begin
                m_mode = 2; m_frames_left = 30; m_crashed = 1;
            end else if (bus.startOfFrame) begin
                m_yfp = m_yfp + int'(bus.speed);
                m_tly = m_yfp >>> 6;
`ifdef ENEMY_LATERAL_DRIFT_EN
                if ((m_x + m_dir > 480) || (m_x + m_dir < 160)) m_dir = -m_dir;
                m_x = m_x + m_dir;
`endif
                if (m_tly >= 480) begin
                    m_mode = 0; m_active = 0; m_done = 1;
                end
            end
        end else begin
            if (bus.startOfFrame) begin
                m_frames_left = m_frames_left - 1;
                if (m_frames_left == 0) begin
                    m_mode = 0; m_active = 0; m_crashed = 0; m_done = 1;
                end
            end
        end
    endtask

    // One clock: model consumes the pre-edge inputs, outputs sampled #1 later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic spawn(input int x, input int spd);
        bus.spawn_x   = 11'(x);
        bus.speed     = 8'(spd);
        bus.spawn_req = 1'b1;
        tick();
        bus.spawn_req = 1'b0;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.topLeftX !== 11'sd0) begin n_fail++; $display("FAIL reset_x got=%0d exp=0", bus.topLeftX); end
        n_checks++; if (bus.topLeftY !== 11'sd0) begin n_fail++; $display("FAIL reset_y got=%0d exp=0", bus.topLeftY); end
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", bus.active); end
        n_checks++; if (bus.crashed !== 1'b0) begin n_fail++; $display("FAIL reset_crashed got=%b exp=0", bus.crashed); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    endtask

    task automatic test_spawn_and_exit();
        int n_done;
        spawn(310, 64);
        n_checks++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL spawn_active got=%b exp=1", bus.active); end
        n_checks++; if (bus.topLeftX !== 11'sd310) begin n_fail++; $display("FAIL spawn_x got=%0d exp=310", bus.topLeftX); end
        n_checks++; if (bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL spawn_y got=%0d exp=-64", bus.topLeftY); end
        frame();
        n_checks++; if (bus.topLeftY !== -11'sd63) begin n_fail++; $display("FAIL step1_y got=%0d exp=-63", bus.topLeftY); end
`ifndef ENEMY_LATERAL_DRIFT_EN
        n_checks++; if (bus.topLeftX !== 11'sd310) begin n_fail++; $display("FAIL x_held got=%0d exp=310", bus.topLeftX); end
`endif
        n_done = 0;
        for (int f = 2; f <= 543; f++) begin
            frame();
            if (bus.done === 1'b1) n_done++;
        end
        n_checks++; if (bus.topLeftY !== 11'sd479 || bus.active !== 1'b1) begin n_fail++; $display("FAIL pre_exit got_y=%0d active=%b exp_y=479 active=1", bus.topLeftY, bus.active); end
        frame();
        if (bus.done === 1'b1) n_done++;
        n_checks++; if (bus.topLeftY !== 11'sd480) begin n_fail++; $display("FAIL exit_y got=%0d exp=480", bus.topLeftY); end
        n_checks++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL exit_active got=%b exp=0", bus.active); end
        tick();
        if (bus.done === 1'b1) n_done++;
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL exit_done_count got=%0d exp=1", n_done); end
    endtask

    task automatic test_fractional();
        int exp_y [4] = '{-64, -63, -63, -62};
        do_reset();
        spawn(200, 32);
        n_checks++; if (bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL frac_spawn got=%0d exp=-64", bus.topLeftY); end
        for (int i = 0; i < 4; i++) begin
            frame();
            n_checks++; if (bus.topLeftY !== 11'(exp_y[i])) begin n_fail++; $display("FAIL frac_f%0d got=%0d exp=%0d", i + 1, bus.topLeftY, exp_y[i]); end
        end
    endtask

    task automatic test_crash();
        do_reset();
        spawn(250, 64);
        for (int i = 0; i < 10; i++) frame();
        bus.collision = 1'b1; tick(); bus.collision = 1'b0;
        n_checks++; if (bus.crashed !== 1'b1 || bus.active !== 1'b1) begin n_fail++; $display("FAIL crash_enter got crashed=%b active=%b exp 1 1", bus.crashed, bus.active); end
        n_checks++; if (bus.topLeftY !== -11'sd54) begin n_fail++; $display("FAIL crash_y got=%0d exp=-54", bus.topLeftY); end
        for (int i = 0; i < 15; i++) frame();
        bus.collision = 1'b1; bus.spawn_req = 1'b1; tick();
        bus.collision = 1'b0; bus.spawn_req = 1'b0;
        for (int i = 0; i < 14; i++) frame();
        n_checks++; if (bus.done !== 1'b0 || bus.crashed !== 1'b1 || bus.topLeftY !== -11'sd54) begin n_fail++; $display("FAIL crash_29 got done=%b crashed=%b y=%0d exp 0 1 -54", bus.done, bus.crashed, bus.topLeftY); end
        frame();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL crash_done got=%b exp=1", bus.done); end
        n_checks++; if (bus.active !== 1'b0 || bus.crashed !== 1'b0) begin n_fail++; $display("FAIL crash_clear got active=%b crashed=%b exp 0 0", bus.active, bus.crashed); end
        tick();
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL crash_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        spawn(100, 64);
        for (int i = 0; i < 3; i++) frame();
        bus.spawn_x = 11'sd200; bus.spawn_req = 1'b1; tick(); bus.spawn_req = 1'b0;
        n_checks++; if (bus.topLeftX !== 11'sd100 && bus.topLeftX !== 11'sd103) begin n_fail++; $display("FAIL spawn_ignored_x got=%0d exp=100", bus.topLeftX); end
        n_checks++; if (bus.topLeftY !== -11'sd61) begin n_fail++; $display("FAIL spawn_ignored_y got=%0d exp=-61", bus.topLeftY); end
        bus.collision = 1'b1; bus.startOfFrame = 1'b1; tick();
        bus.collision = 1'b0; bus.startOfFrame = 1'b0;
        n_checks++; if (bus.crashed !== 1'b1 || bus.topLeftY !== -11'sd61) begin n_fail++; $display("FAIL coll_sof got crashed=%b y=%0d exp 1 -61", bus.crashed, bus.topLeftY); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        spawn(300, 64);
        for (int i = 0; i < 164; i++) frame();
        n_checks++; if (bus.topLeftY !== 11'sd100) begin n_fail++; $display("FAIL mid_y got=%0d exp=100", bus.topLeftY); end
        do_reset();
        n_checks++; if (bus.topLeftY !== 11'sd0 || bus.topLeftX !== 11'sd0 || bus.active !== 1'b0) begin n_fail++; $display("FAIL mid_reset got x=%0d y=%0d active=%b exp 0 0 0", bus.topLeftX, bus.topLeftY, bus.active); end
        spawn(300, 64);
        n_checks++; if (bus.topLeftY !== -11'sd64 || bus.active !== 1'b1) begin n_fail++; $display("FAIL respawn got y=%0d active=%b exp -64 1", bus.topLeftY, bus.active); end
    endtask

`ifdef ENEMY_LATERAL_DRIFT_EN
    task automatic test_drift();
        int exp_x [4] = '{479, 480, 479, 478};
        do_reset();
        spawn(478, 10);
        for (int i = 0; i < 4; i++) begin
            frame();
            n_checks++; if (bus.topLeftX !== 11'(exp_x[i])) begin n_fail++; $display("FAIL drift_f%0d got=%0d exp=%0d", i + 1, bus.topLeftX, exp_x[i]); end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset            = ($urandom_range(0, 999) == 0);
            bus.startOfFrame = ($urandom_range(0, 3) == 0);
            bus.spawn_req    = ($urandom_range(0, 7) == 0);
            bus.collision    = ($urandom_range(0, 149) == 0);
            bus.speed        = 8'($urandom_range(0, 255));
            bus.spawn_x      = 11'($urandom_range(160, 480));
            tick();
            n_checks++; if (bus.topLeftX !== 11'(m_x)) begin n_fail++; $display("FAIL rnd_x c=%0d got=%0d exp=%0d", c, bus.topLeftX, m_x); end
            n_checks++; if (bus.topLeftY !== 11'(m_tly)) begin n_fail++; $display("FAIL rnd_y c=%0d got=%0d exp=%0d", c, bus.topLeftY, m_tly); end
            n_checks++; if (bus.active !== m_active) begin n_fail++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, bus.active, m_active); end
            n_checks++; if (bus.crashed !== m_crashed) begin n_fail++; $display("FAIL rnd_crashed c=%0d got=%b exp=%b", c, bus.crashed, m_crashed); end
            n_checks++; if (bus.done !== m_done) begin n_fail++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, bus.done, m_done); end
        end
        reset = 1'b0; bus.startOfFrame = 1'b0; bus.spawn_req = 1'b0; bus.collision = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset            = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.spawn_req    = 1'b0;
        bus.spawn_x      = '0;
        bus.speed        = '0;
        bus.collision    = 1'b0;
        test_reset();
        test_spawn_and_exit();
        test_fractional();
        test_crash();
        test_same_cycle();
        test_reset_mid();
`ifdef ENEMY_LATERAL_DRIFT_EN
        test_drift();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enemy_car_mover.md
Name: enemy_car_mover

Overview:
- Downstream consumer of the fixed signed 11-bit spawn-column constant generator.
- Takes that X coordinate and spawns one enemy car above the visible road.
- Scrolls the car down the screen once per frame in fixed-point Y.
- Freezes the car on collision for a crash period, then retires it.
- Drives the enemy-car drawing/hit-test stage with top-left coordinates and status flags.

Parameters:
- Y_START, -64: signed spawn Y in pixels (above visible area).
- Y_BOTTOM, 480: signed Y at or beyond which the car has left the screen.
- FP_SHIFT, 6: fixed-point fraction bits; speed is in 1/64 px per frame.
- CRASH_FRAMES, 30: frames the car stays frozen after a collision.
- X_MIN, 160: left drift bound in pixels (optional feature only).
- X_MAX, 480: right drift bound in pixels (optional feature only).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- startOfFrame, in, 1: one-cycle pulse, once per video frame.
- spawn_req, in, 1: request to spawn a car; level or pulse.
- spawn_x, in, 11 signed: spawn column from the constant generator.
- speed, in, 8 unsigned: Y increment per frame in 1/64 px.
- collision, in, 1: car hit by the player; valid any cycle.
- topLeftX, out, 11 signed: car top-left X.
- topLeftY, out, 11 signed: car top-left Y (integer part of Y_fp).
- active, out, 1: car is on screen and must be drawn.
- crashed, out, 1: car is in the crash period.
- done, out, 1: one-cycle pulse when the car retires.

Behaviour:
- Clock and reset: single clock domain (clk). Synchronous, active-high reset.
- Reset:
  - state goes to IDLE.
  - topLeftX = 0, topLeftY = 0; active, crashed and done = 0.
  - Internal Y_fp = 0, crash counter = 0.
  - Reset takes effect from any state, including mid-MOVING or mid-CRASH.
- Internal storage:
  - Y_fp: 17-bit signed, holds Y << FP_SHIFT.
  - topLeftY = Y_fp >>> FP_SHIFT, registered.
  - All outputs are registered.
- IDLE:
  - active = 0, crashed = 0.
  - If spawn_req = 1: latch X = spawn_x and Y_fp = Y_START << FP_SHIFT, go to MOVING.
  - On the next cycle: active = 1, topLeftX = spawn_x, topLeftY = Y_START.
- MOVING:
  - On startOfFrame: Y_fp += speed, with speed sampled on that cycle. New topLeftY is visible on the cycle after the pulse.
  - If the updated Y is >= Y_BOTTOM: go to IDLE, active drops, done pulses for 1 cycle.
  - collision = 1 on any cycle: go to CRASH, load counter = CRASH_FRAMES.
  - collision and startOfFrame on the same cycle: collision wins, no Y update.
  - spawn_req is ignored.
- CRASH:
  - crashed = 1, active = 1, position frozen.
  - Counter decrements on each startOfFrame.
  - When it reaches 0: go to IDLE, clear active and crashed, pulse done.
  - collision and spawn_req are ignored.
- Width and overflow:
  - speed max 255 gives < 4 px/frame.
  - Y is bounded to [Y_START, Y_BOTTOM+4], so Y_fp never overflows.
  - No saturation logic is required.
- spawn_req on the same cycle as done: ignored. A respawn needs spawn_req while in IDLE.

Optional Feature:
- Macro: ENEMY_LATERAL_DRIFT_EN.
- Defined:
  - In MOVING, on each startOfFrame, X += dir.
  - dir is +1 at spawn.
  - dir reverses when the next X would leave [X_MIN, X_MAX]; X then steps back inward.
  - X is frozen in CRASH.
- Undefined:
  - X stays equal to the latched spawn_x.
  - No dir register exists.

Decomposition:
- Package road_fighter_pkg:
  - state enum typedef {IDLE, MOVING, CRASH}.
  - FP_SHIFT.
  - Screen bound constants (Y_START, Y_BOTTOM, X_MIN, X_MAX).
  - Coordinate typedef: logic signed [10:0].
- Sub-module frame_down_counter:
  - Load value, decrement on startOfFrame, zero flag.
  - Used for the crash period.
- All other logic is the FSM plus the position datapath in the top module.

Test Plan:
- Spawn: reset, then spawn_x = 310, speed = 64, spawn_req pulse -> next cycle active = 1, topLeftX = 310, topLeftY = -64; after 1 startOfFrame, topLeftY = -63.
- Full exit: speed = 64, no collision -> after 544 frames topLeftY reaches 480, done pulses once, active = 0.
- Fractional speed: speed = 32 -> topLeftY = -64, -64, -63, -63, -62 over successive frames.
- Crash:
  - collision on the cycle after frame 10 -> crashed = 1, topLeftY frozen at -54.
  - After 30 startOfFrames -> done pulse, active = crashed = 0.
  - A further collision during CRASH does not restart the counter.
- Same-cycle events:
  - collision with startOfFrame -> no Y step, enters CRASH.
  - spawn_req asserted during MOVING -> ignored, position unchanged.
- Reset mid-MOVING at Y = 100 -> next cycle all outputs 0, IDLE; a following spawn_req restarts at Y = -64.
- Drift, with ENEMY_LATERAL_DRIFT_EN defined: spawn_x = 478 -> X = 479, 480, 479, 478 over four frames.
